// File: rtl/bit_serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: streams operand bit pairs MSB
// first through a 1-bit LT/GT cell and reports a one-hot verdict with done.
module bit_serial_mag_comp #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             LT,
    output logic             EQ,
    output logic             GT
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             vlt_q, vlt_d;
    logic             vgt_q, vgt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    logic lt_bit;
    logic gt_bit;
    logic diff_bit;
    logic last_bit;
    logic finish;

    assign lt_bit   = ~sa_q[WIDTH-1] & sb_q[WIDTH-1];
    assign gt_bit   = sa_q[WIDTH-1] & ~sb_q[WIDTH-1];
    assign diff_bit = lt_bit | gt_bit;
    assign last_bit = (cnt_q == CW'(1));
    assign finish   = last_bit
                    | (EARLY_EXIT & ~decided_q & diff_bit);

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        vlt_d     = vlt_q;
        vgt_d     = vgt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        lt_d      = lt_q;
        eq_d      = eq_q;
        gt_d      = gt_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    sa_d      = a;
                    sb_d      = b;
                    cnt_d     = CW'(WIDTH);
                    decided_d = 1'b0;
                    vlt_d     = 1'b0;
                    vgt_d     = 1'b0;
                    busy_d    = 1'b1;
                    lt_d      = 1'b0;
                    eq_d      = 1'b0;
                    gt_d      = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                sa_d  = sa_q << 1;
                sb_d  = sb_q << 1;
                cnt_d = cnt_q - CW'(1);
                // Only the first differing bit pair sets the verdict.
                if (!decided_q && diff_bit) begin
                    decided_d = 1'b1;
                    vlt_d     = lt_bit;
                    vgt_d     = gt_bit;
                end
                if (finish) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    lt_d    = vlt_d;
                    gt_d    = vgt_d;
                    eq_d    = ~decided_d;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            vlt_q     <= 1'b0;
            vgt_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            vlt_q     <= vlt_d;
            vgt_q     <= vgt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign LT   = lt_q;
    assign EQ   = eq_q;
    assign GT   = gt_q;

endmodule
